// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared state encoding and config address map for the SPI sample scheduler
package spi_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } sched_state_t;

    localparam logic [1:0] ADDR_PERIOD = 2'd0;
    localparam logic [1:0] ADDR_EN     = 2'd1;
    localparam logic [1:0] ADDR_CMD    = 2'd2;
    localparam logic [1:0] ADDR_CLR    = 2'd3;

    localparam int OVR_W = 16;

endpackage

// File: rtl/sched_tick_counter.sv
// rtl/sched_tick_counter.sv - reloadable down-counter producing one-cycle sample ticks
module sched_tick_counter #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [NBITS-1:0] load_value,
    input  logic [NBITS-1:0] reload_value,
    output logic             tick
);

    logic [NBITS-1:0] count;

    // A load in the same cycle as a zero count suppresses that tick.
    assign tick = en && !load && (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick) begin
            count <= reload_value;
        end else if (en) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/spi_sample_scheduler.sv
// rtl/spi_sample_scheduler.sv - periodic SPI sampling sequencer; SPI_SCHED_TIMEOUT_EN adds a response timeout
module spi_sample_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int DBITS = 16
`ifdef SPI_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_val,
    output logic             cfg_rdy,
    input  logic [1:0]       cfg_addr,
    input  logic [NBITS-1:0] cfg_data,
    output logic             spi_req_val,
    input  logic             spi_req_rdy,
    output logic [DBITS-1:0] spi_req_msg,
    input  logic             spi_resp_val,
    output logic             spi_resp_rdy,
    input  logic [DBITS-1:0] spi_resp_msg,
    output logic             smp_val,
    input  logic             smp_rdy,
    output logic [DBITS-1:0] smp_msg,
`ifdef SPI_SCHED_TIMEOUT_EN
    output logic             timeout_flag,
`endif
    output logic [OVR_W-1:0] overrun_count,
    output logic             busy
);

    logic [NBITS-1:0] period;
    logic             enable;
    logic [DBITS-1:0] cmd;
    logic             tick;
    logic             cfg_wr;
    logic             clr;
    logic             drop;
    logic             cnt_load;
    logic [NBITS-1:0] cnt_load_value;
    sched_state_t     state;
`ifdef SPI_SCHED_TIMEOUT_EN
    logic [31:0]      wait_cnt;
`endif

    assign cfg_rdy  = 1'b1;
    assign cfg_wr   = cfg_val && cfg_rdy;
    assign clr      = cfg_wr && (cfg_addr == ADDR_CLR);
    assign cnt_load = cfg_wr && ((cfg_addr == ADDR_PERIOD) ||
                                 ((cfg_addr == ADDR_EN) && cfg_data[0]));
    assign cnt_load_value = (cfg_addr == ADDR_PERIOD) ? cfg_data : period;
    // No bypass: a tick in the cycle OUT hands off still counts as dropped.
    assign drop = tick && (state != IDLE);

    sched_tick_counter #(.NBITS(NBITS)) u_tick (
        .clk          (clk),
        .reset        (reset),
        .en           (enable),
        .load         (cnt_load),
        .load_value   (cnt_load_value),
        .reload_value (period),
        .tick         (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            period <= '0;
            enable <= 1'b0;
            cmd    <= '0;
        end else if (cfg_wr) begin
            case (cfg_addr)
                ADDR_PERIOD: period <= cfg_data;
                ADDR_EN:     enable <= cfg_data[0];
                ADDR_CMD:    cmd    <= cfg_data[DBITS-1:0];
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_count <= '0;
        end else if (clr) begin
            overrun_count <= drop ? OVR_W'(1) : '0;
        end else if (drop && (overrun_count != '1)) begin
            overrun_count <= overrun_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            spi_req_val  <= 1'b0;
            spi_req_msg  <= '0;
            spi_resp_rdy <= 1'b0;
            smp_val      <= 1'b0;
            smp_msg      <= '0;
            busy         <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
`ifdef SPI_SCHED_TIMEOUT_EN
            if (clr) timeout_flag <= 1'b0;
`endif
            case (state)
                IDLE: if (tick) begin
                    state       <= REQ;
                    spi_req_val <= 1'b1;
                    spi_req_msg <= cmd;
                    busy        <= 1'b1;
                end
                REQ: if (spi_req_rdy) begin
                    state        <= WAIT;
                    spi_req_val  <= 1'b0;
                    spi_resp_rdy <= 1'b1;
`ifdef SPI_SCHED_TIMEOUT_EN
                    wait_cnt     <= '0;
`endif
                end
                WAIT: begin
                    if (spi_resp_val) begin
                        state        <= OUT;
                        spi_resp_rdy <= 1'b0;
                        smp_val      <= 1'b1;
                        smp_msg      <= spi_resp_msg;
                    end
`ifdef SPI_SCHED_TIMEOUT_EN
                    else if (wait_cnt == 32'(TIMEOUT - 1)) begin
                        state        <= IDLE;
                        spi_resp_rdy <= 1'b0;
                        busy         <= 1'b0;
                        timeout_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                OUT: if (smp_rdy) begin
                    state   <= IDLE;
                    smp_val <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sample_scheduler.sv
// tb/tb_spi_sample_scheduler.sv - scoreboard bench for spi_sample_scheduler
module tb_spi_sample_scheduler;
    import spi_sched_pkg::*;

    typedef struct {
        logic [15:0] msg;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_val = 1'b0;
    logic        cfg_rdy;
    logic [1:0]  cfg_addr = 2'd0;
    logic [31:0] cfg_data = 32'd0;
    logic        spi_req_val;
    logic        spi_req_rdy = 1'b1;
    logic [15:0] spi_req_msg;
    logic        spi_resp_val = 1'b1;
    logic        spi_resp_rdy;
    logic [15:0] spi_resp_msg = 16'd0;
    logic        smp_val;
    logic        smp_rdy = 1'b1;
    logic [15:0] smp_msg;
    logic [15:0] overrun_count;
    logic        busy;
`ifdef SPI_SCHED_TIMEOUT_EN
    logic        timeout_flag;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t req_q[$];
    exp_t smp_q[$];

    spi_sample_scheduler #(
        .NBITS(32),
        .DBITS(16)
`ifdef SPI_SCHED_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .spi_req_val(spi_req_val), .spi_req_rdy(spi_req_rdy), .spi_req_msg(spi_req_msg),
        .spi_resp_val(spi_resp_val), .spi_resp_rdy(spi_resp_rdy), .spi_resp_msg(spi_resp_msg),
        .smp_val(smp_val), .smp_rdy(smp_rdy), .smp_msg(smp_msg),
`ifdef SPI_SCHED_TIMEOUT_EN
        .timeout_flag(timeout_flag),
`endif
        .overrun_count(overrun_count), .busy(busy)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!reset && spi_req_val && spi_req_rdy) begin
            checks++;
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req act=%0h@%0d exp=none", spi_req_msg, cyc);
            end else begin
                exp_t e;
                e = req_q.pop_front();
                if (spi_req_msg !== e.msg || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL req act=%0h@%0d exp=%0h@%0d", spi_req_msg, cyc, e.msg, e.cyc);
                end
            end
        end
        if (!reset && smp_val && smp_rdy) begin
            checks++;
            if (smp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_smp act=%0h@%0d exp=none", smp_msg, cyc);
            end else begin
                exp_t e;
                e = smp_q.pop_front();
                if (smp_msg !== e.msg || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL smp act=%0h@%0d exp=%0h@%0d", smp_msg, cyc, e.msg, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; the write lands on the next edge.
    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d, output int wc);
        cfg_val  = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        wc = cyc;
        @(posedge clk);
        #1;
        cfg_val = 1'b0;
    endtask

    task automatic push(input bit is_req, input logic [15:0] m, input int c);
        exp_t e;
        e.msg = m;
        e.cyc = c;
        if (is_req) req_q.push_back(e);
        else smp_q.push_back(e);
    endtask

    initial begin
        int w;
        int p;
        int wc;
        bit any_req;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_val", 32'(spi_req_val), 32'd0);
        chk("rst_resp_rdy", 32'(spi_resp_rdy), 32'd0);
        chk("rst_smp_val", 32'(smp_val), 32'd0);
        chk("rst_smp_msg", 32'(smp_msg), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun_count), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("cfg_rdy", 32'(cfg_rdy), 32'd1);

        // Basic periodic sampling: period 4, ticks 5 cycles apart.
        spi_resp_msg = 16'h1234;
        cfg_write(ADDR_PERIOD, 32'd4, wc);
        cfg_write(ADDR_CMD, 32'h0011, wc);
        cfg_write(ADDR_EN, 32'd1, w);
        for (int k = 0; k < 3; k++) begin
            push(1'b1, 16'h0011, w + 6 + 5 * k);
            push(1'b0, 16'h1234, w + 8 + 5 * k);
        end
        goto(w + 19);
        cfg_write(ADDR_EN, 32'd0, wc);
        goto(w + 30);
        chk("t1_overrun", 32'(overrun_count), 32'd0);

        // Stalled consumer: ticks during OUT are dropped.
        smp_rdy = 1'b0;
        spi_resp_msg = 16'h2222;
        cfg_write(ADDR_PERIOD, 32'd2, wc);
        cfg_write(ADDR_CMD, 32'h0022, wc);
        cfg_write(ADDR_EN, 32'd1, w);
        push(1'b1, 16'h0022, w + 4);
        push(1'b0, 16'h2222, w + 15);
        push(1'b1, 16'h0022, w + 19);
        push(1'b0, 16'h2222, w + 21);
        for (int c = w + 6; c <= w + 14; c += 4) begin
            goto(c);
            chk("t2_hold_val", 32'(smp_val), 32'd1);
            chk("t2_hold_msg", 32'(smp_msg), 32'h2222);
        end
        goto(w + 15);
        smp_rdy = 1'b1;
        goto(w + 19);
        cfg_write(ADDR_EN, 32'd0, wc);
        goto(w + 25);
        chk("t2_overrun", 32'(overrun_count), 32'd4);
        cfg_write(ADDR_CLR, 32'd0, wc);
        chk("t2_clear", 32'(overrun_count), 32'd0);

        // Period rewrite mid-count, then a rewrite on the tick cycle itself.
        spi_resp_msg = 16'h3333;
        cfg_write(ADDR_CMD, 32'h0033, wc);
        cfg_write(ADDR_PERIOD, 32'hFFFF_FFFF, wc);
        cfg_write(ADDR_EN, 32'd1, w);
        goto(w + 10);
        cfg_write(ADDR_PERIOD, 32'd3, p);
        push(1'b1, 16'h0033, p + 5);
        push(1'b0, 16'h3333, p + 7);
        push(1'b1, 16'h0033, p + 15);
        push(1'b0, 16'h3333, p + 17);
        goto(p + 8);
        cfg_write(ADDR_PERIOD, 32'd5, wc);
        goto(p + 18);
        cfg_write(ADDR_EN, 32'd0, wc);
        goto(p + 25);
        chk("t3_overrun", 32'(overrun_count), 32'd0);

        // Disable while waiting for the response.
        spi_resp_val = 1'b0;
        spi_resp_msg = 16'h4444;
        cfg_write(ADDR_PERIOD, 32'd1, wc);
        cfg_write(ADDR_CMD, 32'h0044, wc);
        cfg_write(ADDR_EN, 32'd1, w);
        push(1'b1, 16'h0044, w + 3);
        push(1'b0, 16'h4444, w + 9);
        goto(w + 5);
        chk("t4_in_wait", 32'(spi_resp_rdy), 32'd1);
        cfg_write(ADDR_EN, 32'd0, wc);
        goto(w + 8);
        spi_resp_val = 1'b1;
        goto(w + 10);
        chk("t4_overrun", 32'(overrun_count), 32'd1);
        any_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (spi_req_val) any_req = 1'b1;
        end
        chk("t4_no_req", 32'(any_req), 32'd0);
        cfg_write(ADDR_CLR, 32'd0, wc);

        // Command rewrite while the request is stalled.
        spi_req_rdy = 1'b0;
        spi_resp_msg = 16'h5555;
        cfg_write(ADDR_CMD, 32'hA5A5, wc);
        cfg_write(ADDR_PERIOD, 32'd9, wc);
        cfg_write(ADDR_EN, 32'd1, w);
        push(1'b1, 16'hA5A5, w + 15);
        push(1'b0, 16'h5555, w + 17);
        push(1'b1, 16'h5A5A, w + 21);
        push(1'b0, 16'h5555, w + 23);
        goto(w + 12);
        cfg_write(ADDR_CMD, 32'h5A5A, wc);
        for (int c = w + 13; c <= w + 14; c++) begin
            goto(c);
            chk("t5_req_val", 32'(spi_req_val), 32'd1);
            chk("t5_req_msg", 32'(spi_req_msg), 32'hA5A5);
        end
        goto(w + 15);
        spi_req_rdy = 1'b1;
        goto(w + 24);
        cfg_write(ADDR_EN, 32'd0, wc);
        goto(w + 30);
        chk("t5_overrun", 32'(overrun_count), 32'd0);

`ifdef SPI_SCHED_TIMEOUT_EN
        spi_resp_val = 1'b0;
        cfg_write(ADDR_PERIOD, 32'd20, wc);
        cfg_write(ADDR_EN, 32'd1, w);
        push(1'b1, 16'h5A5A, w + 22);
        goto(w + 30);
        chk("to_busy_before", 32'(busy), 32'd1);
        goto(w + 31);
        chk("to_busy_after", 32'(busy), 32'd0);
        chk("to_flag_set", 32'(timeout_flag), 32'd1);
        chk("to_no_smp", 32'(smp_val), 32'd0);
        cfg_write(ADDR_EN, 32'd0, wc);
        cfg_write(ADDR_CLR, 32'd0, wc);
        chk("to_flag_clr", 32'(timeout_flag), 32'd0);
        spi_resp_val = 1'b1;
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("smp_q_empty", 32'(smp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
